// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/mask widths, arbiter state and the latched memory request.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } lc3b_arb_state;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } lc3b_arb_port;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask wmask;
  } lc3b_mem_req;

  // A client asserting both read and write is captured as a write.
  function automatic lc3b_mem_req make_req(input logic rd, input logic wr,
                                           input lc3b_word addr, input lc3b_word data,
                                           input lc3b_mem_wmask mask);
    lc3b_mem_req r;
    r.read    = rd & ~wr;
    r.write   = wr;
    r.address = addr;
    r.wdata   = data;
    r.wmask   = mask;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin merge of fetch (A) and LSQ (B) onto one memory port; grant to pmem_* is 1 cycle,
// completion is memory latency + 1. Clients hold until resp; an abandoned transaction still runs to completion.
module mem_port_arbiter
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        mem_read_a,
  input  logic        mem_write_a,
  input  logic [15:0] mem_address_a,
  input  logic [15:0] mem_wdata_a,
  input  logic [1:0]  mem_byte_enable_a,
  output logic        mem_resp_a,
  output logic [15:0] mem_rdata_a,

  input  logic        mem_read_b,
  input  logic        mem_write_b,
  input  logic [15:0] mem_address_b,
  input  logic [15:0] mem_wdata_b,
  input  logic [1:0]  mem_byte_enable_b,
  output logic        mem_resp_b,
  output logic [15:0] mem_rdata_b,

  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  lc3b_arb_state state;
  lc3b_arb_port  last_grant;
  lc3b_mem_req   req;

  logic want_a;
  logic want_b;
  logic pick_b;

  assign want_a = mem_read_a | mem_write_a;
  assign want_b = mem_read_b | mem_write_b;
  // On a tie the port that was not served last wins.
  assign pick_b = want_b & (~want_a | (last_grant == GRANT_A));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_B;
      req        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_b) begin
            req        <= make_req(mem_read_b, mem_write_b, mem_address_b,
                                   mem_wdata_b, mem_byte_enable_b);
            last_grant <= GRANT_B;
            state      <= SERVE_B;
          end else if (want_a) begin
            req        <= make_req(mem_read_a, mem_write_a, mem_address_a,
                                   mem_wdata_a, mem_byte_enable_a);
            last_grant <= GRANT_A;
            state      <= SERVE_A;
          end
        end
        SERVE_A, SERVE_B: begin
          // Dropping the strobes here gives the mandatory idle cycle after each completion.
          if (pmem_resp) begin
            req.read  <= 1'b0;
            req.write <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pmem_read        = req.read;
  assign pmem_write       = req.write;
  assign pmem_address     = req.address;
  assign pmem_wdata       = req.wdata;
  assign pmem_byte_enable = req.wmask;

  // A client that abandoned its request sees no resp.
  assign mem_resp_a  = (state == SERVE_A) & pmem_resp & want_a;
  assign mem_resp_b  = (state == SERVE_B) & pmem_resp & want_b;
  assign mem_rdata_a = pmem_rdata;
  assign mem_rdata_b = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios then random traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd[2];
  logic        wr[2];
  logic [15:0] addr[2];
  logic [15:0] wd[2];
  logic [1:0]  be[2];
  logic        resp_a, resp_b;
  logic [15:0] rdata_a, rdata_b;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .mem_read_a(rd[0]), .mem_write_a(wr[0]), .mem_address_a(addr[0]),
    .mem_wdata_a(wd[0]), .mem_byte_enable_a(be[0]),
    .mem_resp_a(resp_a), .mem_rdata_a(rdata_a),
    .mem_read_b(rd[1]), .mem_write_b(wr[1]), .mem_address_b(addr[1]),
    .mem_wdata_b(wd[1]), .mem_byte_enable_b(be[1]),
    .mem_resp_b(resp_b), .mem_rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  m;
  } req_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // traffic knobs (percent, reset in per mille)
  int p_req, p_abandon, p_wiggle, p_rst, p_noise, fixed_lat;
  bit use_fixed_rdata;
  logic [15:0] fixed_rdata;

  // reference model: the transaction currently owning memory, and the grant history
  int   m_cur;
  req_t m_cap;
  bit   m_show;
  int   grant_log[$];

  // observations
  int obs_log[$];
  int resp_cyc[2];
  int n_resp[2];
  logic [15:0] resp_rdata[2], resp_addr[2], resp_wdata[2];
  logic [1:0]  resp_be[2];
  int n_pread;
  bit got_resp[2];
  bit quiet[2];
  int cnt, lat;

  logic        s_rd[2], s_wr[2];
  logic [15:0] s_addr[2], s_wd[2];
  logic [1:0]  s_be[2];
  logic        s_rst, s_presp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit wa, wb;
    int last, w;
    if (s_rst) begin
      m_cur  = -1;
      m_cap  = '{default: 0};
      m_show = 1;
      grant_log.delete();
    end else if (m_cur >= 0) begin
      if (s_presp) begin
        m_cur  = -1;
        m_show = 0;
      end
    end else begin
      wa = s_rd[0] | s_wr[0];
      wb = s_rd[1] | s_wr[1];
      if (wa | wb) begin
        last  = (grant_log.size() == 0) ? 1 : grant_log[$];
        w     = (wa && wb) ? 1 - last : (wa ? 0 : 1);
        m_cur = w;
        m_cap = '{rd: s_rd[w] & ~s_wr[w], wr: s_wr[w], a: s_addr[w], d: s_wd[w], m: s_be[w]};
        m_show = 1;
        grant_log.push_back(w);
      end
    end
  endtask

  task automatic drive_mem();
    if (pmem_read | pmem_write) begin
      if (cnt == 0) lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
      pmem_resp = (cnt >= lat);
      cnt = pmem_resp ? 0 : cnt + 1;
    end else begin
      cnt = 0;
      pmem_resp = ($urandom_range(0, 99) < p_noise);
    end
    pmem_rdata = use_fixed_rdata ? fixed_rdata : 16'($urandom);
    if (p_rst > 0) rst = ($urandom_range(0, 999) < p_rst);
  endtask

  task automatic new_req(input int i);
    int r;
    r = $urandom_range(0, 15);
    rd[i]   = (r < 8);
    wr[i]   = (r >= 8) || (r == 0);
    addr[i] = {(i == 0) ? 4'h1 : 4'h3, 12'($urandom)} & 16'hFFFE;
    wd[i]   = 16'($urandom);
    be[i]   = 2'($urandom_range(1, 3));
  endtask

  task automatic drive_clients();
    for (int i = 0; i < 2; i++) begin
      if (got_resp[i]) begin
        rd[i] = 0; wr[i] = 0; got_resp[i] = 0;
        continue;
      end
      if (quiet[i] && !(pmem_read | pmem_write)) quiet[i] = 0;
      if (!(rd[i] | wr[i])) begin
        if (!quiet[i] && $urandom_range(0, 99) < p_req) new_req(i);
      end else if ($urandom_range(0, 99) < p_abandon) begin
        rd[i] = 0; wr[i] = 0; quiet[i] = 1;
      end else if ($urandom_range(0, 99) < p_wiggle) begin
        addr[i] = addr[i] + 16'd2;
      end
    end
  endtask

  task automatic check_cycle();
    bit   act;
    logic r;
    act = (m_cur >= 0);
    check_eq("pmem_read", pmem_read, act & m_cap.rd);
    check_eq("pmem_write", pmem_write, act & m_cap.wr);
    if (m_show) begin
      check_eq("pmem_address", pmem_address, m_cap.a);
      check_eq("pmem_wdata", pmem_wdata, m_cap.d);
      check_eq("pmem_byte_enable", pmem_byte_enable, m_cap.m);
    end
    check_eq("mem_resp_a", resp_a, (m_cur == 0) & pmem_resp & (rd[0] | wr[0]));
    check_eq("mem_resp_b", resp_b, (m_cur == 1) & pmem_resp & (rd[1] | wr[1]));
    check_eq("mem_rdata_a", rdata_a, pmem_rdata);
    check_eq("mem_rdata_b", rdata_b, pmem_rdata);
    if (pmem_read) n_pread++;
    for (int i = 0; i < 2; i++) begin
      r = (i == 0) ? resp_a : resp_b;
      if (r === 1'b1) begin
        got_resp[i]   = 1;
        obs_log.push_back(i);
        resp_cyc[i]   = cyc;
        resp_rdata[i] = (i == 0) ? rdata_a : rdata_b;
        resp_addr[i]  = pmem_address;
        resp_wdata[i] = pmem_wdata;
        resp_be[i]    = pmem_byte_enable;
        n_resp[i]++;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        s_rd[i] = rd[i]; s_wr[i] = wr[i]; s_addr[i] = addr[i]; s_wd[i] = wd[i]; s_be[i] = be[i];
      end
      s_rst   = rst;
      s_presp = pmem_resp;
      #1;
      cyc++;
      model_step();
      drive_mem();
      drive_clients();
      #4;
      check_cycle();
    end
  endtask

  task automatic pulse_reset();
    rst = 1;
    run_cycles(1);
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, na, bound;
    rst = 1; pmem_resp = 0; pmem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; wr[i] = 0; addr[i] = '0; wd[i] = '0; be[i] = '0;
      got_resp[i] = 0; quiet[i] = 0; n_resp[i] = 0; resp_cyc[i] = 0;
    end
    p_req = 0; p_abandon = 0; p_wiggle = 0; p_rst = 0; p_noise = 0; fixed_lat = 3;
    use_fixed_rdata = 0; fixed_rdata = '0;
    m_cur = -1; m_cap = '{default: 0}; m_show = 0; cnt = 0; lat = 0; n_pread = 0;

    run_cycles(2);
    check_eq("reset_pmem_read", pmem_read, 0);
    check_eq("reset_pmem_address", pmem_address, 0);
    check_eq("reset_resp_a", resp_a, 0);
    rst = 0;

    // lone read
    use_fixed_rdata = 1; fixed_rdata = 16'hBEEF;
    rd[0] = 1; addr[0] = 16'h1000; be[0] = 2'b11;
    t0 = cyc; n_pread = 0;
    run_cycles(8);
    check_eq("lone_resp_latency", resp_cyc[0] - t0, 4);
    check_eq("lone_rdata", resp_rdata[0], 16'hBEEF);
    check_eq("lone_pmem_read_cycles", n_pread, 4);
    check_eq("lone_no_resp_b", n_resp[1], 0);
    use_fixed_rdata = 0;

    // tie after reset
    pulse_reset();
    obs_log.delete(); fixed_lat = 2;
    rd[0] = 1; addr[0] = 16'h2000;
    wr[1] = 1; addr[1] = 16'h3000; wd[1] = 16'h55AA; be[1] = 2'b01;
    run_cycles(14);
    check_eq("tie_count", obs_log.size(), 2);
    if (obs_log.size() >= 2) begin
      check_eq("tie_first", obs_log[0], 0);
      check_eq("tie_second", obs_log[1], 1);
    end
    check_eq("tie_gap", resp_cyc[1] - resp_cyc[0], 4);
    check_eq("tie_b_address", resp_addr[1], 16'h3000);
    check_eq("tie_b_wdata", resp_wdata[1], 16'h55AA);
    check_eq("tie_b_mask", resp_be[1], 2'b01);

    // fairness under continuous contention
    obs_log.delete(); p_req = 100; bound = 0;
    while (obs_log.size() < 6 && bound < 200) begin
      run_cycles(1);
      bound++;
    end
    p_req = 0;
    check_eq("fair_progress", obs_log.size() >= 6, 1);
    for (int k = 0; k < 6 && k < obs_log.size(); k++) check_eq("fair_order", obs_log[k], k % 2);
    run_cycles(20);

    // abandoned read, B pending behind it
    pulse_reset();
    obs_log.delete(); fixed_lat = 3; na = n_resp[0];
    rd[0] = 1; addr[0] = 16'h4000;
    n_pread = 0;
    run_cycles(2);
    rd[0] = 0;
    wr[1] = 1; addr[1] = 16'h3100; wd[1] = 16'h0F0F; be[1] = 2'b10;
    run_cycles(14);
    check_eq("abandon_no_resp_a", n_resp[0] - na, 0);
    check_eq("abandon_pmem_read_held", n_pread, 4);
    check_eq("abandon_b_served", obs_log.size(), 1);
    if (obs_log.size() >= 1) check_eq("abandon_b_next", obs_log[0], 1);

    // client-side address change during service
    wr[1] = 1; addr[1] = 16'h3000; wd[1] = 16'h1234; be[1] = 2'b11;
    run_cycles(2);
    addr[1] = 16'h3002;
    run_cycles(10);
    check_eq("stable_address", resp_addr[1], 16'h3000);

    // reset in the middle of a read
    fixed_lat = 6; obs_log.delete();
    rd[0] = 1; addr[0] = 16'h5000;
    run_cycles(2);
    rst = 1;
    rd[1] = 1; addr[1] = 16'h3200;
    run_cycles(1);
    check_eq("midrst_pmem_read", pmem_read, 0);
    check_eq("midrst_pmem_write", pmem_write, 0);
    check_eq("midrst_pmem_address", pmem_address, 0);
    check_eq("midrst_pmem_wdata", pmem_wdata, 0);
    check_eq("midrst_pmem_mask", pmem_byte_enable, 0);
    check_eq("midrst_resp_a", resp_a, 0);
    check_eq("midrst_resp_b", resp_b, 0);
    rst = 0;
    run_cycles(24);
    check_eq("midrst_resp_count", obs_log.size() >= 1, 1);
    if (obs_log.size() >= 1) check_eq("midrst_tie_grants_a", obs_log[0], 0);

    // random traffic
    na = n_resp[0] + n_resp[1];
    p_req = 30; p_abandon = 3; p_wiggle = 5; p_rst = 5; p_noise = 15; fixed_lat = -1;
    run_cycles(4000);
    p_rst = 0; rst = 0;
    check_eq("random_progress", (n_resp[0] + n_resp[1] - na) > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-client memory arbiter directly downstream of `cpu_datapath`. It merges memory port A (instruction fetch) and memory port B (load/store queue) onto the single physical memory interface. Each client keeps its existing LC-3b request/hold-until-`resp` protocol. Arbitration is round-robin, so neither fetch nor the LSQ can starve the other.

## Interface
Parameters:
- none; widths come from `lc3b_types` (`lc3b_word` = 16 bits, `lc3b_mem_wmask` = 2 bits).

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_read_a`, `mem_write_a`  in  1 each  port A request.
- `mem_address_a`, `mem_wdata_a`  in  16 each  port A address and write data.
- `mem_byte_enable_a`  in  2  port A write byte mask.
- `mem_resp_a`  out  1  port A transaction complete.
- `mem_rdata_a`  out  16  port A read data.
- `mem_read_b`, `mem_write_b`, `mem_address_b`, `mem_wdata_b`, `mem_byte_enable_b`, `mem_resp_b`, `mem_rdata_b`: port B, same as A.
- `pmem_read`, `pmem_write`  out  1 each  downstream request.
- `pmem_address`, `pmem_wdata`  out  16 each  downstream address and write data.
- `pmem_byte_enable`  out  2  downstream byte mask.
- `pmem_resp`  in  1  downstream completion.
- `pmem_rdata`  in  16  downstream read data.

## Operation
- States: `IDLE`, `SERVE_A`, `SERVE_B` (`lc3b_arb_state`). Register `last_grant` holds A or B.
- `IDLE`:
  - A requests when `read_a|write_a`; B likewise.
  - One requester → grant it.
  - Both request → grant the port that is not `last_grant`.
  - On grant, latch op, address, wdata and mask into the request register, update `last_grant`, and go to `SERVE_x`.
- `SERVE_x`:
  - Drive `pmem_*` from the latched register only; client-side changes are ignored.
  - On `pmem_resp` → go to `IDLE`.
  - If the granted client still asserts read/write that cycle, assert `mem_resp_x`.
- Read and write both asserted by a client is illegal; the arbiter latches it as a write.
- Abandoned request: client drops read/write before `pmem_resp` (flush).
  - The downstream transaction still runs to completion, because memory requires the request held.
  - The response is swallowed and `mem_resp_x` is not asserted.
  - The abandoned client is not re-granted for that transaction.
- `mem_rdata_a` and `mem_rdata_b` both equal `pmem_rdata` combinationally; only `resp` is steered.
- The non-granted `resp` is always 0.

## Timing
- Reset:
  - State = `IDLE`, `last_grant` = B, so A wins the first tie.
  - Request register = 0.
  - All `pmem_*` outputs and `mem_resp_*` = 0.
- `rst` mid-transaction: back to `IDLE` next edge and `pmem_read/write` drop. Aborting the downstream transaction is acceptable only under reset.
- Latency:
  - Request seen in `IDLE` at cycle N → `pmem_read/write` high from N+1.
  - `mem_resp_x` is asserted in the same cycle as `pmem_resp`, combinationally.
  - Total = memory latency + 1.
- After every completion the arbiter spends one `IDLE` cycle. The client has deasserted by then, so no duplicate grant occurs.
- Back-to-back contention: transactions alternate A, B, A, B; each client waits at most one other transaction.
- `pmem_resp` while in `IDLE` is ignored.
- `pmem_*` stays stable from grant until the `pmem_resp` cycle inclusive.

## Structure
- Add `lc3b_arb_state` enum (`IDLE`, `SERVE_A`, `SERVE_B`) to the `lc3b_types` package.
- Add `lc3b_mem_req` struct (`read`, `write`, `address`, `wdata`, `wmask`) to `lc3b_types`; it is used for the latched request.
- Single module; no sub-module.
- `cpu_datapath` is unchanged; the top level instantiates it beside this arbiter.

## Test plan
- Lone read: A reads 0x1000, memory latency 3, rdata 0xBEEF.
  - `pmem_read` high in cycles 1–4; `mem_resp_a` in cycle 4 with `mem_rdata_a` = 0xBEEF.
  - `mem_resp_b` stays 0.
- Tie after reset: A reads 0x2000 and B writes 0x55AA (mask 2'b01) to 0x3000 in the same cycle.
  - A is served first, then `IDLE`, then B.
  - `pmem_write` carries 0x3000/0x55AA/2'b01.
- Fairness: A and B both request continuously for 6 transactions → grant order A,B,A,B,A,B, with one `IDLE` cycle between each.
- Abandon: A reads 0x4000, then drops read 1 cycle after grant.
  - `pmem_read` stays high until `pmem_resp`; `mem_resp_a` never asserts.
  - A pending B request is served next.
- Stability: B changes `mem_address_b` from 0x3000 to 0x3002 while in `SERVE_B` → `pmem_address` holds 0x3000 until `pmem_resp`.
- Reset mid-read: `rst` asserted in cycle 2 of a port A read.
  - Next cycle all outputs are 0 and the state is `IDLE`.
  - The next tie grants A.
